// File: rtl/adder_operand_loader.sv
// rtl/adder_operand_loader.sv - deserialises a chunk stream into an operand pair (a then b) for the wide adder
// Optional frame checking (in_last/frame_err) when LOADER_FRAME_CHECK_EN is defined.
module adder_operand_loader #(
  parameter int ADDER_WIDTH = 97,
  parameter int CHUNK_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
`ifdef LOADER_FRAME_CHECK_EN
  input  logic                   in_last,
  output logic                   frame_err,
`endif
  input  logic [CHUNK_WIDTH-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [ADDER_WIDTH-1:0] a,
  output logic [ADDER_WIDTH-1:0] b,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam int NCHUNK = (ADDER_WIDTH + CHUNK_WIDTH - 1) / CHUNK_WIDTH;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    PRESENT = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ADDER_WIDTH-1:0] shadow_a_q, shadow_a_d;
  logic [ADDER_WIDTH-1:0] shadow_b_q, shadow_b_d;
  logic [ADDER_WIDTH-1:0] a_q, a_d;
  logic [ADDER_WIDTH-1:0] b_q, b_d;
  logic                   out_valid_q, out_valid_d;
  logic                   last_chunk;
  logic [ADDER_WIDTH-1:0] merged;
  logic [ADDER_WIDTH-1:0] chunk_mask;
  logic [ADDER_WIDTH-1:0] chunk_data;
  int                     shamt;
`ifdef LOADER_FRAME_CHECK_EN
  logic                   frame_err_q, frame_err_d;
`endif

  always_comb begin
    in_ready    = (state_q != PRESENT);
    last_chunk  = (cnt_q == LAST_CNT);
    // Shifting inside the operand width drops the excess high bits of the final chunk.
    shamt       = int'(cnt_q) * CHUNK_WIDTH;
    chunk_data  = ADDER_WIDTH'(in_data) << shamt;
    chunk_mask  = ADDER_WIDTH'({CHUNK_WIDTH{1'b1}}) << shamt;
    merged      = (((state_q == LOAD_B) ? shadow_b_q : shadow_a_q) & ~chunk_mask) | chunk_data;

    state_d     = state_q;
    cnt_d       = cnt_q;
    shadow_a_d  = shadow_a_q;
    shadow_b_d  = shadow_b_q;
    a_d         = a_q;
    b_d         = b_q;
    out_valid_d = out_valid_q;

    case (state_q)
      LOAD_A: begin
        if (in_valid) begin
          shadow_a_d = merged;
          cnt_d      = last_chunk ? '0 : cnt_q + CNT_W'(1);
          if (last_chunk) state_d = LOAD_B;
        end
      end
      LOAD_B: begin
        if (in_valid) begin
          shadow_b_d = merged;
          cnt_d      = last_chunk ? '0 : cnt_q + CNT_W'(1);
          if (last_chunk) begin
            a_d         = shadow_a_q;
            b_d         = merged;
            out_valid_d = 1'b1;
            state_d     = PRESENT;
          end
        end
      end
      PRESENT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = LOAD_A;
        end
      end
      default: state_d = LOAD_A;
    endcase
  end

`ifdef LOADER_FRAME_CHECK_EN
  // in_last is only legal on the final chunk of operand b; any mismatch latches an error.
  always_comb begin
    frame_err_d = frame_err_q;
    if (in_valid && in_ready &&
        (in_last != ((state_q == LOAD_B) && last_chunk))) begin
      frame_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_err_q <= 1'b0;
    else        frame_err_q <= frame_err_d;
  end

  assign frame_err = frame_err_q;
`else
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD_A;
      cnt_q       <= '0;
      shadow_a_q  <= '0;
      shadow_b_q  <= '0;
      a_q         <= '0;
      b_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shadow_a_q  <= shadow_a_d;
      shadow_b_q  <= shadow_b_d;
      a_q         <= a_d;
      b_q         <= b_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign out_valid = out_valid_q;

endmodule
